// File: rtl/ncl_pkg.sv
// ncl_pkg: shared phase enum, weight field width and weighted-sum width helper for the NCL threshold bank
package ncl_pkg;
  typedef enum logic {EXP_DATA = 1'b0, EXP_NULL = 1'b1} phase_e;
  localparam int WGT_W = 4;
  localparam int MAX_IN = 64;
  function automatic int wsum_width(input logic [WGT_W*MAX_IN-1:0] wgt, input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += int'(wgt[WGT_W*i+:WGT_W]);
    return $clog2(s + 1);
  endfunction
endpackage

// File: rtl/ncl_th_gate.sv
// ncl_th_gate: one weighted threshold gate with hysteresis (set at threshold, clear on all-NULL, else hold)
module ncl_th_gate
  import ncl_pkg::*;
#(
  parameter int IN = 3,
  parameter int THR = 2,
  parameter logic [WGT_W*IN-1:0] WGT = {IN{4'd1}},
  parameter logic RST_VAL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IN-1:0] in,
  output logic          out
);
  localparam int SW = wsum_width((WGT_W*MAX_IN)'(WGT), IN);
  logic [SW-1:0] sum;
  // weighted sum of the asserted inputs; width sized so it cannot overflow
  always_comb begin
    sum = '0;
    for (int i = 0; i < IN; i++) sum = sum + (in[i] ? SW'(WGT[WGT_W*i+:WGT_W]) : SW'(0));
  end
  // hysteresis: threshold reached sets, fully NULL inputs clear, anything in between holds
  always_ff @(posedge clk)
    out <= rst ? RST_VAL : (32'(sum) >= THR) ? 1'b1 : ~|in ? 1'b0 : out;
endmodule

// File: rtl/ncl_th_bank.sv
// ncl_th_bank: bank of CH NCL threshold gates with completion detect, DATA/NULL phase tracking and wavefront counter
// Optional NCL_MONO_CHECK_EN adds a sticky input monotonicity checker on port mono_err.
module ncl_th_bank
  import ncl_pkg::*;
#(
  parameter int CH = 4,
  parameter int IN = 3,
  parameter int THR = 2,
  parameter logic [WGT_W*IN-1:0] WGT = {IN{4'd1}},
  parameter logic [CH-1:0] RST_VAL = '0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH*IN-1:0] in,
  output logic [CH-1:0]    out,
  output logic             all_data,
  output logic             all_null,
  output logic             phase,
  output logic [CNT_W-1:0] wave_cnt
`ifdef NCL_MONO_CHECK_EN
  , output logic           mono_err
`endif
);
  phase_e state, state_n;
  logic   wrap;
  for (genvar c = 0; c < CH; c++) begin : g_gate
    ncl_th_gate #(.IN(IN), .THR(THR), .WGT(WGT), .RST_VAL(RST_VAL[c])) u_gate (
      .clk(clk),
      .rst(rst),
      .in (in[c*IN+:IN]),
      .out(out[c])
    );
  end
  assign all_data = &out;
  assign all_null = ~|out;
  assign phase    = state;
  // phase transitions: a full DATA wavefront arms NULL, a full NULL wavefront completes one cycle
  always_comb begin
    wrap    = (state == EXP_NULL) && all_null;
    state_n = (state == EXP_DATA && all_data) ? EXP_NULL : wrap ? EXP_DATA : state;
  end
  // phase register and wrapping completed-cycle counter; reset-to-DATA banks start expecting NULL
  always_ff @(posedge clk)
    if (rst) begin
      state    <= |RST_VAL ? EXP_NULL : EXP_DATA;
      wave_cnt <= '0;
    end else begin
      state    <= state_n;
      wave_cnt <= wave_cnt + CNT_W'(wrap);
    end
`ifdef NCL_MONO_CHECK_EN
  logic [CH*IN-1:0] in_q;
  logic             viol;
  assign viol = (state == EXP_DATA) ? |(in_q & ~in) : |(~in_q & in);
  // inputs may only rise while expecting DATA and only fall while expecting NULL
  always_ff @(posedge clk)
    if (rst) begin
      in_q     <= '0;
      mono_err <= 1'b0;
    end else begin
      in_q     <= in;
      mono_err <= mono_err | viol;
    end
`endif
endmodule

// File: tb/tb_ncl_th_bank.sv
// tb_ncl_th_bank: directed and randomized checks of three bank configurations against an arithmetic reference model
module tb_ncl_th_bank;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] in  = '0;
  logic [1:0] o [3];
  logic       ad [3];
  logic       an [3];
  logic       ph [3];
  logic [7:0] wc [3];
  logic       me [3];
  int         w [3][3] = '{'{1, 1, 1}, '{1, 1, 1}, '{1, 1, 2}};
  int         thr [3] = '{2, 2, 3};
  logic [1:0] rv [3] = '{2'b00, 2'b11, 2'b00};
  logic [1:0] mo [3];
  logic       mp [3];
  int         mc [3];
  logic [5:0] mq;
  logic       mme;
  int         checks = 0;
  int         passed = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  ncl_th_bank #(.CH(2), .IN(3), .THR(2), .WGT({3{4'd1}}), .RST_VAL(2'b00), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in(in), .out(o[0]), .all_data(ad[0]), .all_null(an[0]),
    .phase(ph[0]), .wave_cnt(wc[0])
`ifdef NCL_MONO_CHECK_EN
    , .mono_err(me[0])
`endif
  );
  ncl_th_bank #(.CH(2), .IN(3), .THR(2), .WGT({3{4'd1}}), .RST_VAL(2'b11), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in(in), .out(o[1]), .all_data(ad[1]), .all_null(an[1]),
    .phase(ph[1]), .wave_cnt(wc[1])
`ifdef NCL_MONO_CHECK_EN
    , .mono_err(me[1])
`endif
  );
  ncl_th_bank #(.CH(2), .IN(3), .THR(3), .WGT({4'd2, 4'd1, 4'd1}), .RST_VAL(2'b00), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .in(in), .out(o[2]), .all_data(ad[2]), .all_null(an[2]),
    .phase(ph[2]), .wave_cnt(wc[2])
`ifdef NCL_MONO_CHECK_EN
    , .mono_err(me[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int s;
    logic [2:0] b;
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        mo[d] = rv[d];
        mp[d] = |rv[d];
        mc[d] = 0;
      end
      mq  = '0;
      mme = 1'b0;
    end else begin
      if (mp[0] ? |(~mq & in) : |(mq & ~in)) mme = 1'b1;
      mq = in;
      for (int d = 0; d < 3; d++) begin
        if (!mp[d] && mo[d] == 2'b11) mp[d] = 1'b1;
        else if (mp[d] && mo[d] == 2'b00) begin
          mp[d] = 1'b0;
          mc[d] = (mc[d] + 1) % 256;
        end
        for (int c = 0; c < 2; c++) begin
          b = in[c*3+:3];
          s = 0;
          for (int i = 0; i < 3; i++) s += b[i] ? w[d][i] : 0;
          if (s >= thr[d]) mo[d][c] = 1'b1;
          else if (b == 3'b000) mo[d][c] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("out%0d", d), 32'(o[d]), 32'(mo[d]));
      chk($sformatf("all_data%0d", d), 32'(ad[d]), 32'(mo[d] == 2'b11));
      chk($sformatf("all_null%0d", d), 32'(an[d]), 32'(mo[d] == 2'b00));
      chk($sformatf("phase%0d", d), 32'(ph[d]), 32'(mp[d]));
      chk($sformatf("wave_cnt%0d", d), 32'(wc[d]), 32'(mc[d]));
    end
`ifdef NCL_MONO_CHECK_EN
    chk("mono_err0", 32'(me[0]), 32'(mme));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_rv0", 32'(o[0]), 32'h0);
    chk("rst_phase_rv0", 32'(ph[0]), 32'h0);
    chk("rst_out_rv11", 32'(o[1]), 32'h3);
    chk("rst_phase_rv11", 32'(ph[1]), 32'h1);
    rst = 1'b0;
    in  = '0;
    repeat (5) tick();
    chk("idle_all_null", 32'(an[0]), 32'h1);
    chk("idle_wave_cnt", 32'(wc[0]), 32'h0);
    chk("rv11_cleared_cnt", 32'(wc[1]), 32'h1);
    in = 6'b000_001;
    tick();
    chk("ch0_below_thr", 32'(o[0][0]), 32'h0);
    in = 6'b000_011;
    tick();
    chk("ch0_at_thr", 32'(o[0][0]), 32'h1);
    chk("wgt_011_below", 32'(o[2][0]), 32'h0);
    in = 6'b000_010;
    tick();
    chk("ch0_hold", 32'(o[0][0]), 32'h1);
    in = 6'b000_101;
    tick();
    chk("wgt_101_set", 32'(o[2][0]), 32'h1);
    in = 6'b000_000;
    tick();
    chk("ch0_cleared", 32'(o[0][0]), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 256; k++) begin
      in = 6'b011_011;
      tick();
      if (k == 0) chk("data_all_data", 32'(ad[0]), 32'h1);
      tick();
      if (k == 0) chk("data_phase", 32'(ph[0]), 32'h1);
      in = 6'b000_000;
      tick();
      tick();
      if (k == 0) chk("null_wave_cnt", 32'(wc[0]), 32'h1);
    end
    chk("wrap_wave_cnt", 32'(wc[0]), 32'h0);
`ifdef NCL_MONO_CHECK_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in  = 6'b000_011;
    tick();
    in = 6'b000_001;
    tick();
    tick();
    chk("mono_set", 32'(me[0]), 32'h1);
    tick();
    chk("mono_sticky", 32'(me[0]), 32'h1);
    rst = 1'b1;
    tick();
    chk("mono_rst", 32'(me[0]), 32'h0);
    rst = 1'b0;
`endif
    for (int k = 0; k < 400; k++) begin
      int r;
      r   = int'($urandom_range(0, 3));
      rst = ($urandom_range(0, 49) == 0);
      in  = (r == 0) ? 6'h00 : (r == 1) ? 6'h3f : 6'($urandom);
      tick();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
